// File: rtl/random_zero_scheduler_pkg.sv
// Shared types and helpers for the zero-sharing randomness scheduler.
package random_zero_scheduler_pkg;

  typedef logic [1:0] bv2_t;

  typedef enum logic {S_FILL, S_FULL} rzs_state_t;

  // Fresh random words consumed by one zero-sharing of the given share count.
  function automatic int unsigned num_zero_randoms(input int unsigned num_shares);
    case (num_shares)
      2:       return 1;
      3:       return 2;
      4:       return 4;
      default: return 5;
    endcase
  endfunction

endpackage

// File: rtl/random_zero_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter; the pointer register is kept by the parent.
module random_zero_scheduler_rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] pointer,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner
);

  logic          found;
  logic [PW-1:0] idx;

  // Search cyclically starting just after the last winner.
  always_comb begin
    grant  = '0;
    winner = pointer;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= int'(N); k++) begin
      idx = PW'((int'(pointer) + k) % int'(N));
      if (enable && !found && request[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

endmodule

// File: rtl/random_zero_scheduler.sv
// Collects fresh PRNG words into zero-sharings and hands each one to a single
// requester, round-robin. Every word is used by exactly one grant.
module random_zero_scheduler
  import random_zero_scheduler_pkg::*;
#(
  parameter int unsigned NUM_SHARES = 2,
  parameter type         T          = bv2_t,
  parameter int unsigned NUM_REQ    = 3
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic                  in_flush,
  input  T                      in_rand,
  input  logic                  in_rand_valid,
  output logic                  out_rand_ready,
  input  logic [NUM_REQ-1:0]    in_request,
  output logic [NUM_REQ-1:0]    out_grant,
  output T [NUM_SHARES-1:0]     out_shares,
  output logic                  out_valid
);

  localparam int unsigned NUM_NEEDED = num_zero_randoms(NUM_SHARES);
  localparam int unsigned CNT_W      = $clog2(NUM_NEEDED + 1);
  localparam int unsigned IDX_W      = $clog2(NUM_SHARES);
  localparam int unsigned PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_SHARES < 2 || NUM_SHARES > 5) begin : g_bad_shares
    $error("random_zero_scheduler: NUM_SHARES must be 2..5");
  end
  if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_req
    $error("random_zero_scheduler: NUM_REQ must be 1..8");
  end

  rzs_state_t           state;
  logic [CNT_W-1:0]     count;
  logic [IDX_W-1:0]     wr_idx;
  T                     rand_buf [NUM_SHARES];
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     winner;
  logic [NUM_REQ-1:0]   arb_grant;
  logic                 grant_fire;
  logic                 accept;
  T [NUM_SHARES-1:0]    sharing;

  assign grant_fire     = (state == S_FULL) && (|in_request);
  assign out_rand_ready = !in_reset && ((state == S_FILL) || grant_fire);
  assign accept         = in_rand_valid && out_rand_ready;
  assign wr_idx         = IDX_W'(count);

  random_zero_scheduler_rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_arb (
    .request (in_request),
    .pointer (ptr),
    .enable  (grant_fire),
    .grant   (arb_grant),
    .winner  (winner)
  );

  // Zero-sharing built from the buffered words; shares always XOR to zero.
  always_comb begin
    sharing = '0;
    for (int i = 0; i < int'(NUM_SHARES); i++) begin
      if (NUM_SHARES == 2) begin
        sharing[i] = rand_buf[0];
      end else if (NUM_SHARES == 3) begin
        sharing[i] = (i == 2) ? (rand_buf[0] ^ rand_buf[1]) : rand_buf[i];
      end else begin
        sharing[i] = rand_buf[i] ^ rand_buf[(i + 1) % int'(NUM_SHARES)];
      end
    end
  end

  // Fill/full control, buffer and registered outputs; flush beats grant and accept.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state      <= S_FILL;
      count      <= '0;
      ptr        <= PTR_W'(NUM_REQ - 1);
      out_valid  <= 1'b0;
      out_grant  <= '0;
      out_shares <= '0;
      for (int i = 0; i < int'(NUM_SHARES); i++) begin
        rand_buf[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      out_grant <= '0;
      if (in_flush) begin
        state <= S_FILL;
        count <= '0;
      end else if (grant_fire) begin
        out_valid  <= 1'b1;
        out_grant  <= arb_grant;
        out_shares <= sharing;
        ptr        <= winner;
        if (accept) begin
          rand_buf[0] <= in_rand;
          count       <= CNT_W'(1);
          state       <= (NUM_NEEDED == 1) ? S_FULL : S_FILL;
        end else begin
          count <= '0;
          state <= S_FILL;
        end
      end else if (accept) begin
        rand_buf[wr_idx] <= in_rand;
        count            <= count + CNT_W'(1);
        if (count + CNT_W'(1) == CNT_W'(NUM_NEEDED)) begin
          state <= S_FULL;
        end
      end
    end
  end

endmodule

// File: tb/tb_random_zero_scheduler.sv
// Drives four scheduler instances (2..5 shares) with one shared stimulus and
// compares each against a queue-based reference model.
module tb_random_zero_scheduler;
  import random_zero_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  bv2_t       rnd;
  logic       valid;
  logic [2:0] req;

  logic [3:0]       rdy_a;
  logic [3:0]       vld_a;
  logic [3:0][2:0]  gnt_a;
  logic [3:0][9:0]  sh_a;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned NS = g + 2;
    bv2_t [NS-1:0] sh;
    logic [2:0]    gnt;
    logic          vld;
    logic          rdy;

    random_zero_scheduler #(
      .NUM_SHARES (NS),
      .T          (bv2_t),
      .NUM_REQ    (3)
    ) dut (
      .in_clock       (clk),
      .in_reset       (rst),
      .in_flush       (flush),
      .in_rand        (rnd),
      .in_rand_valid  (valid),
      .out_rand_ready (rdy),
      .in_request     (req),
      .out_grant      (gnt),
      .out_shares     (sh),
      .out_valid      (vld)
    );

    assign rdy_a[g] = rdy;
    assign vld_a[g] = vld;
    assign gnt_a[g] = gnt;
    assign sh_a[g]  = 10'(sh);
  end

  // Reference model state: collected words, last winner, expected outputs.
  bv2_t       mq [4][$];
  int         lw [4];
  logic       ev [4];
  logic [2:0] eg [4];
  logic [9:0] es [4];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  function automatic int nn_of(input int ns);
    case (ns)
      2:       return 1;
      3:       return 2;
      default: return ns;
    endcase
  endfunction

  function automatic logic [9:0] zero_share(input int ns, input bv2_t r [5]);
    logic [9:0] s;
    bv2_t       v;
    s = '0;
    for (int i = 0; i < ns; i++) begin
      if (ns == 2)      v = r[0];
      else if (ns == 3) v = (i == 2) ? (r[0] ^ r[1]) : r[i];
      else              v = r[i] ^ r[(i + 1) % ns];
      s[2*i +: 2] = v;
    end
    return s;
  endfunction

  function automatic bv2_t xor_all(input int ns, input logic [9:0] s);
    bv2_t x;
    x = '0;
    for (int i = 0; i < ns; i++) x ^= s[2*i +: 2];
    return x;
  endfunction

  task automatic check(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s ns=%0d observed=%0h expected=%0h", tag, g + 2, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < 4; g++) begin
      mq[g].delete();
      lw[g] = 2;
      ev[g] = 1'b0;
      eg[g] = '0;
      es[g] = '0;
    end
  endtask

  task automatic check_outputs();
    for (int g = 0; g < 4; g++) begin
      check("valid",  g, 32'(vld_a[g]), 32'(ev[g]));
      check("grant",  g, 32'(gnt_a[g]), 32'(eg[g]));
      check("shares", g, 32'(sh_a[g]),  32'(es[g]));
      check("xor0",   g, 32'(xor_all(g + 2, sh_a[g])), 32'(0));
    end
  endtask

  // One clock: apply inputs, check ready before the edge, outputs after it.
  task automatic step(input logic v, input bv2_t r, input logic [2:0] rq, input logic fl);
    bv2_t buf5 [5];
    logic full, fire, rdy_exp, acc;
    int   w;
    valid = v;
    rnd   = r;
    req   = rq;
    flush = fl;
    #1;
    for (int g = 0; g < 4; g++) begin
      full    = (mq[g].size() == nn_of(g + 2));
      fire    = full && (rq != 3'b000);
      rdy_exp = !full || fire;
      check("ready", g, 32'(rdy_a[g]), 32'(rdy_exp));
      acc   = v && rdy_exp;
      ev[g] = 1'b0;
      eg[g] = '0;
      if (fl) begin
        mq[g].delete();
      end else begin
        if (fire) begin
          w = -1;
          for (int k = 1; k <= 3; k++) begin
            if (w < 0 && rq[(lw[g] + k) % 3]) w = (lw[g] + k) % 3;
          end
          for (int i = 0; i < 5; i++) buf5[i] = (i < mq[g].size()) ? mq[g][i] : 2'b00;
          es[g] = zero_share(g + 2, buf5);
          ev[g] = 1'b1;
          eg[g] = 3'(1 << w);
          lw[g] = w;
          mq[g].delete();
        end
        if (acc) mq[g].push_back(r);
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    valid = 1'b0;
    rnd   = '0;
    req   = '0;
    model_reset();
    #3;
    for (int g = 0; g < 4; g++) check("reset_ready", g, 32'(rdy_a[g]), 32'(0));
    check_outputs();
    #4 rst = 1'b0;
    @(posedge clk);
    #1;

    // Three-share sharing of 01,10 for requester 0.
    step(1'b1, 2'b01, 3'b001, 1'b0);
    step(1'b1, 2'b10, 3'b001, 1'b0);
    step(1'b0, 2'b00, 3'b001, 1'b0);
    check("t1_shares", 1, 32'(sh_a[1][5:0]), 32'(6'b11_10_01));
    check("t1_grant",  1, 32'(gnt_a[1]), 32'(3'b001));

    // All requesting with a continuous stream: grants rotate.
    for (int i = 0; i < 12; i++) step(1'b1, 2'($urandom), 3'b111, 1'b0);

    // Two shares, back-to-back grants to requester 1.
    step(1'b0, 2'b00, 3'b000, 1'b1);
    step(1'b1, 2'd3, 3'b010, 1'b0);
    step(1'b1, 2'd1, 3'b010, 1'b0);
    check("t3_sh_a", 0, 32'(sh_a[0][3:0]), 32'(4'b1111));
    step(1'b1, 2'd2, 3'b010, 1'b0);
    check("t3_sh_b", 0, 32'(sh_a[0][3:0]), 32'(4'b0101));
    step(1'b0, 2'd0, 3'b010, 1'b0);
    check("t3_sh_c", 0, 32'(sh_a[0][3:0]), 32'(4'b1010));
    check("t3_grant", 0, 32'(gnt_a[0]), 32'(3'b010));

    // Four shares: hold while idle in FULL, then serve requester 2.
    step(1'b0, 2'b00, 3'b000, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 3'b000, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 2'b00, 3'b000, 1'b0);
    check("t4_ready", 2, 32'(rdy_a[2]), 32'(0));
    step(1'b0, 2'b00, 3'b100, 1'b0);
    check("t4_shares", 2, 32'(sh_a[2][7:0]), 32'(8'hDD));
    check("t4_grant",  2, 32'(gnt_a[2]), 32'(3'b100));

    // Five shares: flush after three words discards them.
    step(1'b0, 2'b00, 3'b000, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd3, 3'b000, 1'b0);
    step(1'b1, 2'd3, 3'b000, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 2'(i), 3'b000, 1'b0);
    step(1'b0, 2'b00, 3'b001, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom), $urandom_range(0, 24) == 0);
    end

    // Asynchronous reset while a grant is on the outputs.
    step(1'b0, 2'b00, 3'b000, 1'b1);
    step(1'b1, 2'd1, 3'b001, 1'b0);
    step(1'b0, 2'd0, 3'b001, 1'b0);
    check("t6_pre_valid", 0, 32'(vld_a[0]), 32'(1));
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    #2 rst = 1'b0;
    step(1'b1, 2'd2, 3'b101, 1'b0);
    step(1'b0, 2'd0, 3'b101, 1'b0);
    check("t6_tie_grant", 0, 32'(gnt_a[0]), 32'(3'b001));
    step(1'b0, 2'd0, 3'b000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
